midi_merge_arbiter: RTL and testbench
=====================================

Name: midi_merge_arbiter

Overview:
- Merges N MIDI input byte FIFOs into one output FIFO, e.g. several UART-RX FIFOs feeding one UART-TX FIFO.
- Arbitration is round-robin and message-atomic: once a port is granted, it holds the grant until a complete MIDI message has been copied.
- Per-port running status is tracked so that data-first messages are sized correctly.
- Sits between the RX-side fifo instances (read port) and the TX-side fifo instance (write port).

Parameters:
- N_PORTS, 4, number of source FIFOs (2..8)
- WIDTH, 8, byte width (fixed 8 for MIDI; parameter kept for FIFO compatibility)
- RD_LAT, 2, cycles from src_rd pulse or grant until head data on src_data is valid
- TIMEOUT, 65535, idle cycles before a starved message is aborted (used only with the optional feature)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- src_empty_n  in  N_PORTS  per-source "FIFO not empty"
- src_data  in  N_PORTS*WIDTH  per-source head byte; port k occupies bits [k*8+7:k*8]
- src_rd  out  N_PORTS  one-cycle pop strobe, at most one bit high
- dst_full_n  in  1  destination FIFO "not full"
- dst_wr  out  1  one-cycle push strobe
- dst_data  out  WIDTH  byte to push, valid while dst_wr=1
- grant  out  N_PORTS  one-hot current owner; 0 when idle
- busy  out  1  high while a message is in progress

Behaviour:
- Reset values: all outputs 0; rr_ptr=0; all running-status regs 0 (none); state IDLE.
- All outputs are registered.
- FSM states: IDLE, SETTLE, CHECK, XFER.
- IDLE:
  - Scan ports from rr_ptr upward, wrapping modulo N_PORTS.
  - First port with src_empty_n=1 wins: set grant, busy=1, next state SETTLE.
  - If none are non-empty, stay in IDLE.
- SETTLE: wait RD_LAT cycles, then go to CHECK.
- CHECK:
  - If src_empty_n[g]=0: stay in CHECK and hold the grant.
  - Else if dst_full_n=0: stall in CHECK.
  - Else go to XFER.
- XFER (exactly one cycle): dst_wr=1, src_rd[g]=1, dst_data=src_data[g], then classify the byte:
  - Realtime F8-FF: passed through; does not alter need, sysex or running status.
  - Status 8x,9x,Ax,Bx,Ex: need=2, running[g]=byte.
  - Status Cx,Dx: need=1, running[g]=byte.
  - Status F1,F3: need=1; F2: need=2; F6, F4, F5: need=0. All of these clear running[g].
  - Status F0: sysex=1, clears running[g].
  - Status F7: sysex=0, need=0.
  - Any other non-realtime status seen while sysex=1 ends the sysex and is then sized as above.
  - Data byte with need>0: need-1.
  - Data byte with need=0 and sysex=0 starts a running-status message: need = len(running[g]) minus 2. If running[g]=0 (none), the byte is a complete 1-byte message.
- After XFER:
  - Message complete (need=0 and sysex=0 after the update): grant=0, busy=0, rr_ptr=g+1 mod N_PORTS, next IDLE.
  - Otherwise next SETTLE.
- Throughput: one byte per RD_LAT+2 cycles minimum.
- Destination full check: dst_full_n is sampled only in CHECK, at least RD_LAT cycles after the previous dst_wr. This is safe because this block is the sole writer.
- A realtime byte received while idle is a complete message by itself.
- Reset mid-message: the in-flight message state is discarded; the destination may hold a truncated message.

Optional Feature:
- Macro: MIDI_MERGE_TIMEOUT_EN.
- Defined:
  - A 16-bit counter increments while in CHECK with src_empty_n[g]=0 and clears on any XFER.
  - On reaching TIMEOUT: abort the message (need=0, sysex=0, running[g]=0), release the grant, advance rr_ptr, go to IDLE.
  - Nothing is written to the destination on abort.
- Undefined: no counter; a starved source holds the grant indefinitely.

Decomposition:
- Package midi_pkg holds:
  - state encoding constants;
  - MIDI constants: STATUS_SYSEX_START=F0, SYSEX_END=F7, REALTIME_MIN=F8;
  - the msg_len(status) function, returning a length of 1..3 with 0 meaning sysex.
- One sub-module, rr_arbiter: combinational round-robin pick of the first request at or after rr_ptr, producing a one-hot output and a valid flag.

Test Plan:
- Port 0 supplies 90 3C 7F; others empty -> three dst_wr pulses with 90, 3C, 7F in order; grant=0001 throughout; then idle; rr_ptr=1.
- Port 0 supplies 90 3C 7F and port 1 supplies B0 07 64, both loaded before start -> output is 90 3C 7F B0 07 64 with no interleave.
- Port 2 supplies 90 40 7F 41 7F (running status) -> both messages forwarded; the grant releases after 7F at byte 3, re-grants, and releases again after byte 5.
- Port 0 supplies F0 7E 01 F8 02 F7 -> all six bytes forwarded; the F8 does not end sysex; grant is held until F7.
- Port 0 supplies C5 with dst_full_n=0 for 10 cycles -> no dst_wr until full_n rises; C5 is written RD_LAT+2 cycles later at most.
- With MIDI_MERGE_TIMEOUT_EN and TIMEOUT=16: port 0 supplies 90 3C then starves; port 1 supplies F8 -> after 16 cycles port 0's grant is dropped, then port 1's F8 is forwarded.

Source files
------------

// File: rtl/midi_merge_arbiter_pkg.sv
// Shared MIDI constants, FSM state encoding and message sizing for midi_merge_arbiter.
package midi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_XFER
  } state_t;

  localparam logic [7:0] STATUS_SYSEX_START = 8'hF0;
  localparam logic [7:0] SYSEX_END          = 8'hF7;
  localparam logic [7:0] REALTIME_MIN       = 8'hF8;

  // Total message length for a status byte; 0 marks an open-ended sysex.
  function automatic logic [1:0] msg_len(input logic [7:0] status);
    logic [1:0] len;
    len = 2'd1;
    if (status == STATUS_SYSEX_START)
      len = 2'd0;
    else if (status[7:4] == 4'hC || status[7:4] == 4'hD)
      len = 2'd2;
    else if (status[7:4] != 4'hF)
      len = 2'd3;
    else if (status == 8'hF1 || status == 8'hF3)
      len = 2'd2;
    else if (status == 8'hF2)
      len = 2'd3;
    return len;
  endfunction

endpackage

// File: rtl/midi_merge_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr_i, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);

  logic [PW:0]   sum;
  logic [PW-1:0] k;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    sum     = '0;
    k       = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr_i} + (PW+1)'(i);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      k = sum[PW-1:0];
      if (!valid_o && req_i[k]) begin
        valid_o  = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
  end

endmodule

// File: rtl/midi_merge_arbiter.sv
// Round-robin, message-atomic merge of N MIDI source FIFOs into one destination FIFO.
// Define MIDI_MERGE_TIMEOUT_EN to abort a message whose source starves for TIMEOUT cycles.
//  state  | meaning
//  IDLE   | no owner; pick next non-empty source starting at rr_ptr
//  SETTLE | owner's head byte propagating (RD_LAT cycles)
//  CHECK  | wait for source byte and destination space
//  XFER   | one byte pushed/popped; message tracking updated
module midi_merge_arbiter
  import midi_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int WIDTH   = 8,
  parameter int RD_LAT  = 2,
  parameter int TIMEOUT = 65535
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_PORTS-1:0]         src_empty_n,
  input  logic [N_PORTS*WIDTH-1:0]   src_data,
  output logic [N_PORTS-1:0]         src_rd,
  input  logic                       dst_full_n,
  output logic                       dst_wr,
  output logic [WIDTH-1:0]           dst_data,
  output logic [N_PORTS-1:0]         grant,
  output logic                       busy
);

  localparam int PW = $clog2(N_PORTS);
  localparam logic [7:0] SETTLE_LAST = 8'(RD_LAT - 1);

  state_t               state_q, state_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d, gidx_q, gidx_d, pick_idx, ptr_next;
  logic [N_PORTS-1:0]   pick_gnt;
  logic                 pick_valid;
  logic [7:0]           settle_q, settle_d;
  logic [1:0]           need_q, need_d;
  logic                 sysex_q, sysex_d;
  logic [WIDTH-1:0]     run_q [N_PORTS];
  logic [WIDTH-1:0]     run_d [N_PORTS];
  logic [N_PORTS-1:0]   src_rd_q, src_rd_d, grant_q, grant_d;
  logic                 dst_wr_q, dst_wr_d, busy_q, busy_d;
  logic [WIDTH-1:0]     dst_data_q, dst_data_d, head;
  logic [7:0]           xbyte;

`ifdef MIDI_MERGE_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] tmo_q, tmo_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT != 0);
`endif

  rr_arbiter #(.N(N_PORTS), .PW(PW)) u_rr (
    .req_i   (src_empty_n),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign head     = src_data[gidx_q*WIDTH +: WIDTH];
  assign xbyte    = dst_data_q[7:0];
  assign ptr_next = (gidx_q == PW'(N_PORTS - 1)) ? '0 : gidx_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gidx_d     = gidx_q;
    settle_d   = settle_q;
    need_d     = need_q;
    sysex_d    = sysex_q;
    run_d      = run_q;
    src_rd_d   = '0;
    dst_wr_d   = 1'b0;
    dst_data_d = dst_data_q;
    grant_d    = grant_q;
    busy_d     = busy_q;
`ifdef MIDI_MERGE_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d  = pick_gnt;
          gidx_d   = pick_idx;
          busy_d   = 1'b1;
          settle_d = SETTLE_LAST;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) state_d = ST_CHECK;
        else                settle_d = settle_q - 8'd1;
      end
      ST_CHECK: begin
        if (!src_empty_n[gidx_q]) begin
`ifdef MIDI_MERGE_TIMEOUT_EN
          if (tmo_q == TMO_LAST) begin
            need_d         = 2'd0;
            sysex_d        = 1'b0;
            run_d[gidx_q]  = '0;
            grant_d        = '0;
            busy_d         = 1'b0;
            rr_ptr_d       = ptr_next;
            tmo_d          = '0;
            state_d        = ST_IDLE;
          end else begin
            tmo_d = tmo_q + 16'd1;
          end
`endif
        end else if (dst_full_n) begin
          src_rd_d   = grant_q;
          dst_wr_d   = 1'b1;
          dst_data_d = head;
          state_d    = ST_XFER;
        end
      end
      ST_XFER: begin
`ifdef MIDI_MERGE_TIMEOUT_EN
        tmo_d = '0;
`endif
        // Realtime bytes fall through every branch and leave tracking untouched.
        if (xbyte >= REALTIME_MIN) begin
          need_d = need_q;
        end else if (xbyte[7]) begin
          sysex_d = 1'b0;
          need_d  = 2'd0;
          if (xbyte == STATUS_SYSEX_START) begin
            sysex_d       = 1'b1;
            run_d[gidx_q] = '0;
          end else if (xbyte != SYSEX_END) begin
            need_d = msg_len(xbyte) - 2'd1;
            if (xbyte[7:4] == 4'hF) run_d[gidx_q] = '0;
            else                    run_d[gidx_q] = dst_data_q;
          end
        end else if (need_q != 2'd0) begin
          need_d = need_q - 2'd1;
        end else if (!sysex_q && run_q[gidx_q] != '0) begin
          need_d = msg_len(run_q[gidx_q][7:0]) - 2'd2;
        end

        if (need_d == 2'd0 && !sysex_d) begin
          grant_d  = '0;
          busy_d   = 1'b0;
          rr_ptr_d = ptr_next;
          state_d  = ST_IDLE;
        end else begin
          settle_d = SETTLE_LAST;
          state_d  = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      gidx_q     <= '0;
      settle_q   <= '0;
      need_q     <= '0;
      sysex_q    <= 1'b0;
      src_rd_q   <= '0;
      dst_wr_q   <= 1'b0;
      dst_data_q <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      for (int i = 0; i < N_PORTS; i++) run_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gidx_q     <= gidx_d;
      settle_q   <= settle_d;
      need_q     <= need_d;
      sysex_q    <= sysex_d;
      src_rd_q   <= src_rd_d;
      dst_wr_q   <= dst_wr_d;
      dst_data_q <= dst_data_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      run_q      <= run_d;
    end
  end

  assign src_rd   = src_rd_q;
  assign dst_wr   = dst_wr_q;
  assign dst_data = dst_data_q;
  assign grant    = grant_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_midi_merge_arbiter.sv
// Directed bench for midi_merge_arbiter with an in-bench expected-stream model and per-cycle compare.
// Define MIDI_MERGE_TIMEOUT_EN to also exercise the starvation abort (TIMEOUT=16).
module tb_midi_merge_arbiter;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int RDL = 2;
`ifdef MIDI_MERGE_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 65535;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   src_empty_n, src_rd, grant;
  logic [N*W-1:0] src_data;
  logic           dst_full_n = 1'b1;
  logic           dst_wr, busy;
  logic [W-1:0]   dst_data;

  midi_merge_arbiter #(.N_PORTS(N), .WIDTH(W), .RD_LAT(RDL), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .src_empty_n(src_empty_n), .src_data(src_data),
    .src_rd(src_rd), .dst_full_n(dst_full_n), .dst_wr(dst_wr), .dst_data(dst_data),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int port; logic [7:0] b; bit last;} exp_t;

  int checks = 0, failures = 0, cyc = 0, nwr = 0, n_rise = 0;
  bit chk_on = 0, strict = 1;
  exp_t expq[$];
  logic [7:0] got[$];
  logic [7:0] mem [N][64];
  int wrp [N];
  int rdp [N];
  logic [7:0] dl [N][RDL];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Source FIFOs: a pop shows the new head on src_data RD_LAT cycles later.
  always_comb begin
    src_empty_n = '0;
    src_data    = '0;
    for (int k = 0; k < N; k++) begin
      src_empty_n[k]     = (wrp[k] != rdp[k]);
      src_data[k*W +: W] = dl[k][RDL-1];
    end
  end

  always @(posedge clk) begin : fifo_model
    int nr;
    cyc++;
    for (int k = 0; k < N; k++) begin
      nr = rdp[k];
      if (reset) nr = 0;
      else if (src_rd[k]) begin
        check("pop_nonempty", 64'(rdp[k] != wrp[k]), 64'd1);
        if (rdp[k] != wrp[k]) nr = rdp[k] + 1;
      end
      rdp[k]   <= nr;
      dl[k][0] <= (nr < wrp[k]) ? mem[k][nr] : 8'hEE;
      for (int j = 1; j < RDL; j++) dl[k][j] <= dl[k][j-1];
    end
  end

  // Compare DUT outputs to the expected (port, byte, last) stream each cycle.
  always @(negedge clk) begin : cmp
    exp_t e;
    int lat_ref;
    logic [N-1:0] prev_grant, hold_gnt;
    bit pend_rel, pend_hold, first_of_msg;
    if (reset || !chk_on) begin
      pend_rel = 0; pend_hold = 0; first_of_msg = 1; prev_grant = '0; hold_gnt = '0;
    end else begin
      check("busy", 64'(busy), 64'(grant != '0));
      check("src_rd", 64'(src_rd), dst_wr ? 64'(grant) : 64'd0);
      check("grant_onehot0", 64'($onehot0(grant)), 64'd1);
      if (pend_rel)  check("release_after_msg", 64'(grant), 64'd0);
      if (pend_hold) check("hold_mid_msg", 64'(grant), 64'(hold_gnt));
      pend_rel = 0; pend_hold = 0;
      if (grant != prev_grant && grant != '0) begin
        check("grant_from_idle", 64'(prev_grant), 64'd0);
        lat_ref = cyc;
        n_rise++;
      end
      if (dst_wr) begin
        nwr++;
        got.push_back(dst_data);
        if (expq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_wr: got %0h expected none", dst_data);
        end else begin
          e = expq.pop_front();
          check("dst_data", 64'(dst_data), 64'(e.b));
          check("wr_owner", 64'(grant), 64'(1) << e.port);
          if (strict) check(first_of_msg ? "lat_first" : "lat_next",
                            64'(cyc - lat_ref), first_of_msg ? 64'(RDL + 1) : 64'(RDL + 2));
          lat_ref = cyc;
          first_of_msg = e.last;
          pend_rel = e.last;
          pend_hold = !e.last;
          hold_gnt = grant;
        end
      end
      prev_grant = grant;
    end
  end

  // Load n bytes (MSB first) into a source FIFO; lastm marks message-final bytes.
  task automatic msg(input int port, input int n, input logic [63:0] bytes, input logic [7:0] lastm);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.port = port;
      e.b    = bytes[(n-1-i)*8 +: 8];
      e.last = lastm[n-1-i];
      mem[port][wrp[port]] = e.b;
      wrp[port]++;
      expq.push_back(e);
    end
  endtask

  function automatic logic [63:0] pack_got();
    logic [63:0] v = '0;
    foreach (got[i]) v = {v[55:0], got[i]};
    return v;
  endfunction

  task automatic drain(input string name);
    int n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!(expq.size() == 0 && grant == '0 && src_empty_n == '0) && n < 300);
    check({name, "_drain"}, 64'(n < 300), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    chk_on = 0;
    @(negedge clk);
    reset = 1'b1;
    dst_full_n = 1'b1;
    for (int k = 0; k < N; k++) wrp[k] = 0;
    expq.delete(); got.delete();
    nwr = 0;
    repeat (3) @(negedge clk);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_src_rd", 64'(src_rd), 64'd0);
    check("rst_dst_wr", 64'(dst_wr), 64'd0);
    check("rst_dst_data", 64'(dst_data), 64'd0);
    reset = 1'b0;
    chk_on = 1;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int n0, t0, w;
    for (int k = 0; k < N; k++) begin wrp[k] = 0; rdp[k] = 0; end
    do_reset();

    // Single note-on, then rr_ptr=1 picks port 1 ahead of port 0.
    msg(0, 3, 64'h903C7F, 8'b001);
    drain("t1");
    check("t1_nwr", 64'(nwr), 64'd3);
    msg(1, 2, 64'hC106, 8'b01);
    msg(0, 2, 64'hC005, 8'b01);
    drain("t1b");
    check("t1_rr_seq", pack_got(), 64'h903C7FC106C005);

    // Two ports loaded together: no interleave.
    do_reset();
    msg(0, 3, 64'h903C7F, 8'b001);
    msg(1, 3, 64'hB00764, 8'b001);
    drain("t2");
    check("t2_seq", pack_got(), 64'h903C7FB00764);

    // Running status on port 2: two grants.
    n_rise = 0;
    msg(2, 5, 64'h90407F417F, 8'b00101);
    drain("t3");
    check("t3_grants", 64'(n_rise), 64'd2);

    // Sysex with embedded realtime holds the grant until F7.
    n_rise = 0;
    msg(0, 6, 64'hF07E01F802F7, 8'b000001);
    drain("t4");
    check("t4_grants", 64'(n_rise), 64'd1);

    // Sizing corner cases.
    msg(3, 1, 64'hFE, 8'b1);            drain("rt_idle");
    msg(3, 1, 64'h40, 8'b1);            drain("data_no_running");
    msg(3, 3, 64'hC31011, 8'b011);      drain("cx_running");
    msg(1, 4, 64'hF201F802, 8'b0001);   drain("f2_rt_inside");
    msg(2, 2, 64'hF640, 8'b11);         drain("f6_clears_running");
    msg(0, 5, 64'hF001903C7F, 8'b00001); drain("status_ends_sysex");
    msg(0, 2, 64'h4142, 8'b01);         drain("running_after_sysex");

    // Destination full stall.
    do_reset();
    strict = 0;
    dst_full_n = 1'b0;
    msg(0, 2, 64'hC521, 8'b01);
    repeat (10) @(negedge clk);
    #1;
    check("full_no_wr", 64'(nwr), 64'd0);
    check("full_grant_held", 64'(grant), 64'd1);
    t0 = cyc;
    dst_full_n = 1'b1;
    for (int i = 0; i < 10 && nwr == 0; i++) begin @(negedge clk); #1; end
    check("full_release_lat", 64'((cyc - t0) >= 1 && (cyc - t0) <= RDL + 2), 64'd1);
    drain("t5");
    strict = 1;

    // Starved mid-message, then reset discards running status.
    n0 = nwr;
    msg(0, 2, 64'h903C, 8'b00);
    repeat (14) @(negedge clk);
    #1;
    check("starve_nwr", 64'(nwr - n0), 64'd2);
    check("starve_hold", 64'(grant), 64'd1);
    do_reset();
    msg(0, 1, 64'h40, 8'b1);
    drain("post_reset_running");

`ifdef MIDI_MERGE_TIMEOUT_EN
    do_reset();
    msg(0, 2, 64'h903C, 8'b00);
    msg(1, 1, 64'hF8, 8'b1);
    for (int i = 0; i < 40 && nwr < 2; i++) begin @(negedge clk); #1; end
    w = cyc;
    for (int i = 0; i < 60 && grant == 4'b0001; i++) begin @(negedge clk); #1; end
    check("tmo_drop_window", 64'((cyc - w) >= TMO && (cyc - w) <= TMO + RDL + 2), 64'd1);
    drain("tmo");
    check("tmo_seq", pack_got(), 64'h903CF8);
`else
    w = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
